// File: rtl/uart_pkg.sv
// Shared UART types and helpers for the configurable receiver and transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the RX pin plus a delayed copy for falling-edge detection.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_rx_serial,
  output logic o_rx_s,
  output logic o_fall_edge
);

  logic r_meta_p0;
  logic r_sync_p1;
  logic r_prev_p2;

  // All stages reset to the idle line level so reset never looks like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta_p0 <= 1'b1;
      r_sync_p1 <= 1'b1;
      r_prev_p2 <= 1'b1;
    end else begin
      r_meta_p0 <= i_rx_serial;
      r_sync_p1 <= r_meta_p0;
      r_prev_p2 <= r_sync_p1;
    end
  end

  assign o_rx_s      = r_sync_p1;
  assign o_fall_edge = r_prev_p2 & ~r_sync_p1;

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: data width, parity and stop count set by parameters,
// 3-sample majority vote per bit, per-frame parity/framing/break status.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int      FPGA_CLK_FREQ = 50000000,
  parameter int      BAUDRATE      = 115200,
  parameter int      DATA_BITS     = 8,
  parameter parity_e PARITY        = PAR_NONE,
  parameter int      STOP_BITS     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_rx_serial,
  output logic                 o_rx_dv,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(FPGA_CLK_FREQ, BAUDRATE);
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  if (CLKS_PER_BIT < 4) begin : g_err_cpb
    $error("uart_rx_cfg: CLKS_PER_BIT must be at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_data
    $error("uart_rx_cfg: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
    $error("uart_rx_cfg: STOP_BITS must be in 1..2");
  end

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic parity_error(input logic [DATA_BITS-1:0] d, input logic p);
    case (PARITY)
      PAR_EVEN: return ^{d, p};
      PAR_ODD:  return ~(^{d, p});
      default:  return 1'b0;
    endcase
  endfunction

  logic w_rx_s;
  logic w_fall;

  uart_rx_sync u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_rx_serial (i_rx_serial),
    .o_rx_s      (w_rx_s),
    .o_fall_edge (w_fall)
  );

  rx_state_e            r_state,   w_state_nxt;
  logic [CNT_W-1:0]     r_cnt,     w_cnt_nxt;
  logic [IDX_W-1:0]     r_bit_idx, w_bit_idx_nxt;
  logic                 r_stop_idx, w_stop_idx_nxt;
  logic [1:0]           r_smp,     w_smp_nxt;
  logic [DATA_BITS-1:0] r_shift,   w_shift_nxt;
  logic                 r_pbit,    w_pbit_nxt;
  logic                 r_ferr,    w_ferr_nxt;
  logic                 r_any_one, w_any_one_nxt;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_par_err, r_frame_err, r_break, r_dv;
  logic                 w_decide, w_last, w_voted, w_load, w_break;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_stop_idx_nxt = r_stop_idx;
    w_smp_nxt      = r_smp;
    w_shift_nxt    = r_shift;
    w_pbit_nxt     = r_pbit;
    w_ferr_nxt     = r_ferr;
    w_any_one_nxt  = r_any_one;
    w_load         = 1'b0;
    w_break        = 1'b0;
    w_decide       = (r_cnt == CNT_W'(HALF + 1));
    w_last         = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));
    w_voted        = majority3(r_smp[0], r_smp[1], w_rx_s);

    if (r_state != ST_IDLE) begin
      if (r_cnt == CNT_W'(HALF - 1)) w_smp_nxt[0] = w_rx_s;
      if (r_cnt == CNT_W'(HALF))     w_smp_nxt[1] = w_rx_s;
      w_cnt_nxt = w_last ? '0 : r_cnt + 1'b1;
    end

    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt     = '0;
        w_bit_idx_nxt = '0;
        if (w_fall) begin
          w_state_nxt    = ST_START;
          w_cnt_nxt      = CNT_W'(1);
          w_stop_idx_nxt = 1'b0;
          w_ferr_nxt     = 1'b0;
          w_any_one_nxt  = 1'b0;
        end
      end
      ST_START: begin
        if (w_decide && w_voted) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_last) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_decide) begin
          w_shift_nxt[r_bit_idx] = w_voted;
          w_any_one_nxt          = r_any_one | w_voted;
        end
        if (w_last) begin
          if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
            w_bit_idx_nxt = '0;
            w_state_nxt   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (w_decide) begin
          w_pbit_nxt    = w_voted;
          w_any_one_nxt = r_any_one | w_voted;
        end
        if (w_last) w_state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (w_decide) begin
          w_ferr_nxt    = r_ferr | ~w_voted;
          w_any_one_nxt = r_any_one | w_voted;
          // Leave on the last stop decision, not its end, to tolerate a fast sender
          if (r_stop_idx == 1'(STOP_BITS - 1)) begin
            w_load      = 1'b1;
            w_break     = ~(r_any_one | w_voted);
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        end else if (w_last) begin
          w_stop_idx_nxt = r_stop_idx + 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_stop_idx  <= 1'b0;
      r_smp       <= '0;
      r_shift     <= '0;
      r_pbit      <= 1'b0;
      r_ferr      <= 1'b0;
      r_any_one   <= 1'b0;
      r_rx_data   <= '0;
      r_par_err   <= 1'b0;
      r_frame_err <= 1'b0;
      r_break     <= 1'b0;
      r_dv        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_stop_idx <= w_stop_idx_nxt;
      r_smp      <= w_smp_nxt;
      r_shift    <= w_shift_nxt;
      r_pbit     <= w_pbit_nxt;
      r_ferr     <= w_ferr_nxt;
      r_any_one  <= w_any_one_nxt;
      r_dv       <= w_load;
      if (w_load) begin
        r_rx_data   <= r_shift;
        r_par_err   <= parity_error(r_shift, r_pbit);
        r_frame_err <= w_ferr_nxt;
        r_break     <= w_break;
      end
    end
  end

  assign o_rx_dv      = r_dv;
  assign o_rx_data    = r_rx_data;
  assign o_parity_err = r_par_err;
  assign o_frame_err  = r_frame_err;
  assign o_break      = r_break;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three instances (8N1, 8E1, 8N2) at 10 clocks per bit.
module tb_uart_rx_cfg;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

  logic       dv_a, perr_a, ferr_a, brk_a, busy_a;
  logic [7:0] data_a;
  logic       dv_b, perr_b, ferr_b, brk_b, busy_b;
  logic [7:0] data_b;
  logic       dv_c, perr_c, ferr_c, brk_c, busy_c;
  logic [7:0] data_c;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int na = 0, nb = 0, nc = 0;
  int la_cyc = 0;
  logic [7:0] hist_a [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_cfg #(.FPGA_CLK_FREQ(1000000), .BAUDRATE(100000), .DATA_BITS(8),
                .PARITY(PAR_NONE), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .i_rx_serial(rx_a), .o_rx_dv(dv_a), .o_rx_data(data_a),
    .o_parity_err(perr_a), .o_frame_err(ferr_a), .o_break(brk_a), .o_busy(busy_a));

  uart_rx_cfg #(.FPGA_CLK_FREQ(1000000), .BAUDRATE(100000), .DATA_BITS(8),
                .PARITY(PAR_EVEN), .STOP_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .i_rx_serial(rx_b), .o_rx_dv(dv_b), .o_rx_data(data_b),
    .o_parity_err(perr_b), .o_frame_err(ferr_b), .o_break(brk_b), .o_busy(busy_b));

  uart_rx_cfg #(.FPGA_CLK_FREQ(1000000), .BAUDRATE(100000), .DATA_BITS(8),
                .PARITY(PAR_NONE), .STOP_BITS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .i_rx_serial(rx_c), .o_rx_dv(dv_c), .o_rx_data(data_c),
    .o_parity_err(perr_c), .o_frame_err(ferr_c), .o_break(brk_c), .o_busy(busy_c));

  // Pulse counters sampled 1 ns after the active edge
  always @(posedge clk) begin
    #1;
    if (dv_a) begin
      hist_a[na % 8] <= data_a;
      la_cyc <= cyc;
      na <= na + 1;
    end
    if (dv_b) nb <= nb + 1;
    if (dv_c) nc <= nc + 1;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input int ln, input logic v);
    case (ln)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Drive n bits LSB first, 10 clocks each; optionally invert bit gbit for one clock at offset 5
  task automatic drive_bits(input int ln, input logic [15:0] bits, input int n, input int gbit);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 10; k++) begin
        set_line(ln, (i == gbit && k == 5) ? ~bits[i] : bits[i]);
        @(posedge clk);
        #1;
      end
    end
    set_line(ln, 1'b1);
  endtask

  task automatic drive_fast_a(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_a = bits[i];
      #98;
    end
    rx_a = 1'b1;
  endtask

  task automatic test_reset();
    idle(3);
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
    tests++; if (dv_a !== 1'b0) begin fails++; $display("FAIL reset_dv: got %b expected 0", dv_a); end
    tests++; if (data_a !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", data_a); end
    tests++; if ({perr_a, ferr_a, brk_a} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {perr_a, ferr_a, brk_a}); end
    rst_n = 1'b1;
    idle(5);
    tests++; if ({busy_a, busy_b, busy_c} !== 3'b000) begin fails++; $display("FAIL post_reset_busy: got %b expected 000", {busy_a, busy_b, busy_c}); end
  endtask

  task automatic test_basic();
    int c0, n0;
    c0 = cyc;
    n0 = na;
    drive_bits(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10, -1);
    idle(20);
    tests++; if (na !== n0 + 1) begin fails++; $display("FAIL basic_count: got %0d expected %0d", na, n0 + 1); end
    tests++; if (data_a !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h expected a5", data_a); end
    tests++; if ({perr_a, ferr_a, brk_a} !== 3'b000) begin fails++; $display("FAIL basic_flags: got %b expected 000", {perr_a, ferr_a, brk_a}); end
    // 97 clocks from the synchronised edge plus 2 synchroniser stages
    tests++; if (la_cyc - c0 !== 99) begin fails++; $display("FAIL basic_latency: got %0d expected 99", la_cyc - c0); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL basic_busy: got %b expected 0", busy_a); end
  endtask

  task automatic test_parity();
    int n0;
    n0 = nb;
    drive_bits(1, {5'b0, 1'b1, 1'b1, 8'h37, 1'b0}, 11, -1);
    idle(20);
    tests++; if (nb !== n0 + 1) begin fails++; $display("FAIL par_ok_count: got %0d expected %0d", nb, n0 + 1); end
    tests++; if (data_b !== 8'h37) begin fails++; $display("FAIL par_ok_data: got %h expected 37", data_b); end
    tests++; if (perr_b !== 1'b0) begin fails++; $display("FAIL par_ok_err: got %b expected 0", perr_b); end
    drive_bits(1, {5'b0, 1'b1, 1'b0, 8'h37, 1'b0}, 11, -1);
    idle(20);
    tests++; if (nb !== n0 + 2) begin fails++; $display("FAIL par_bad_count: got %0d expected %0d", nb, n0 + 2); end
    tests++; if (perr_b !== 1'b1) begin fails++; $display("FAIL par_bad_err: got %b expected 1", perr_b); end
    tests++; if (ferr_b !== 1'b0) begin fails++; $display("FAIL par_bad_ferr: got %b expected 0", ferr_b); end
  endtask

  task automatic test_stop2();
    int n0;
    n0 = nc;
    drive_bits(2, {5'b0, 1'b0, 1'b1, 8'h5A, 1'b0}, 11, -1);
    idle(20);
    tests++; if (nc !== n0 + 1) begin fails++; $display("FAIL stop2_count: got %0d expected %0d", nc, n0 + 1); end
    tests++; if (data_c !== 8'h5A) begin fails++; $display("FAIL stop2_data: got %h expected 5a", data_c); end
    tests++; if ({ferr_c, brk_c} !== 2'b10) begin fails++; $display("FAIL stop2_flags: got %b expected 10", {ferr_c, brk_c}); end
  endtask

  task automatic test_break();
    int n0;
    n0 = na;
    rx_a = 1'b0;
    idle(200);
    tests++; if (na !== n0 + 1) begin fails++; $display("FAIL break_count: got %0d expected %0d", na, n0 + 1); end
    tests++; if (data_a !== 8'h00) begin fails++; $display("FAIL break_data: got %h expected 00", data_a); end
    tests++; if ({brk_a, ferr_a} !== 2'b11) begin fails++; $display("FAIL break_flags: got %b expected 11", {brk_a, ferr_a}); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL break_busy: got %b expected 0", busy_a); end
    rx_a = 1'b1;
    idle(50);
    tests++; if (na !== n0 + 1) begin fails++; $display("FAIL break_retrigger: got %0d expected %0d", na, n0 + 1); end
  endtask

  task automatic test_noise();
    int n0;
    n0 = na;
    rx_a = 1'b0;
    idle(3);
    rx_a = 1'b1;
    idle(30);
    tests++; if (na !== n0) begin fails++; $display("FAIL glitch_count: got %0d expected %0d", na, n0); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL glitch_busy: got %b expected 0", busy_a); end
    drive_bits(0, {6'b0, 1'b1, 8'hFF, 1'b0}, 10, 4);
    idle(20);
    tests++; if (na !== n0 + 1) begin fails++; $display("FAIL vote_count: got %0d expected %0d", na, n0 + 1); end
    tests++; if (data_a !== 8'hFF) begin fails++; $display("FAIL vote_data: got %h expected ff", data_a); end
    tests++; if ({perr_a, ferr_a, brk_a} !== 3'b000) begin fails++; $display("FAIL vote_flags: got %b expected 000", {perr_a, ferr_a, brk_a}); end
  endtask

  task automatic test_back_to_back();
    int n0, n1;
    n0 = na;
    drive_fast_a({6'b0, 1'b1, 8'h01, 1'b0}, 10);
    drive_fast_a({6'b0, 1'b1, 8'h80, 1'b0}, 10);
    @(posedge clk);
    #1;
    idle(30);
    tests++; if (na !== n0 + 2) begin fails++; $display("FAIL b2b_count: got %0d expected %0d", na, n0 + 2); end
    tests++; if (hist_a[n0 % 8] !== 8'h01) begin fails++; $display("FAIL b2b_first: got %h expected 01", hist_a[n0 % 8]); end
    tests++; if (hist_a[(n0 + 1) % 8] !== 8'h80) begin fails++; $display("FAIL b2b_second: got %h expected 80", hist_a[(n0 + 1) % 8]); end
    n1 = na;
    rx_a = 1'b0;
    idle(30);
    tests++; if (busy_a !== 1'b1) begin fails++; $display("FAIL midframe_busy: got %b expected 1", busy_a); end
    rst_n = 1'b0;
    #1;
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b expected 0", busy_a); end
    tests++; if (data_a !== 8'h00) begin fails++; $display("FAIL rst_data: got %h expected 00", data_a); end
    rx_a = 1'b1;
    idle(3);
    rst_n = 1'b1;
    idle(150);
    tests++; if (na !== n1) begin fails++; $display("FAIL rst_no_dv: got %0d expected %0d", na, n1); end
    tests++; if (busy_a !== 1'b0) begin fails++; $display("FAIL rst_idle: got %b expected 0", busy_a); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop2();
    test_break();
    test_noise();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
